// File: rtl/traffic_light_ctrl_param.sv
// traffic_light_ctrl_param
// Pedestrian-crossing controller: car green/yellow/red and pedestrian walk/stop.
// A prescaler divides clk into one-second ticks; every state entry restarts
// both the prescaler and the seconds counter so each timed state lasts an
// exact number of whole seconds. A push on N is latched in req and served
// once the car-green minimum time has elapsed.
// Optional feature: define NIGHT_FLASH_EN to add the night input and the
// flashing-yellow NIGHT state.
module traffic_light_ctrl_param #(
  parameter int CLK_PER_SEC = 1000,
  parameter int CNT_W       = 16,
  parameter int T_GREEN_MIN = 20,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 10,
  parameter int T_FLASH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       N,
`ifdef NIGHT_FLASH_EN
  input  logic       night,
`endif
  output logic       car_g,
  output logic       car_y,
  output logic       car_r,
  output logic       ped_walk,
  output logic       ped_stop,
  output logic       req_pend,
  output logic [2:0] state
);

  localparam logic [2:0] S_GREEN  = 3'd0;
  localparam logic [2:0] S_YELLOW = 3'd1;
  localparam logic [2:0] S_ALLRED = 3'd2;
  localparam logic [2:0] S_WALK   = 3'd3;
  localparam logic [2:0] S_FLASH  = 3'd4;
`ifdef NIGHT_FLASH_EN
  localparam logic [2:0] S_NIGHT  = 3'd5;
`endif

  localparam logic [CNT_W-1:0] PS_LAST = CNT_W'(CLK_PER_SEC - 1);
  localparam logic [CNT_W-1:0] PS_HALF = CNT_W'(CLK_PER_SEC / 2);
  localparam logic [CNT_W-1:0] SEC_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TG_MIN  = CNT_W'(T_GREEN_MIN);
  localparam logic [CNT_W-1:0] TY      = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] TA      = CNT_W'(T_ALLRED);
  localparam logic [CNT_W-1:0] TW      = CNT_W'(T_WALK);
  localparam logic [CNT_W-1:0] TF      = CNT_W'(T_FLASH);

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] presc_reg, presc_next;
  logic [CNT_W-1:0] sec_reg, sec_next;
  logic [CNT_W-1:0] sec_inc;
  logic             req_reg, req_next;
  logic             tick;
  logic             entering;
  logic             serving;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_GREEN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Prescaler, seconds counter and latched request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_reg <= '0;
      sec_reg   <= '0;
      req_reg   <= 1'b0;
    end else begin
      presc_reg <= presc_next;
      sec_reg   <= sec_next;
      req_reg   <= req_next;
    end
  end

  // Second boundary detection; sec_inc is the post-increment value that
  // the transition conditions look at (saturates instead of wrapping)
  always_comb begin
    tick    = (presc_reg == PS_LAST);
    sec_inc = (sec_reg == SEC_MAX) ? sec_reg : sec_reg + CNT_W'(1);
  end

  // Next-state logic: every move happens on a second boundary
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_GREEN: begin
`ifdef NIGHT_FLASH_EN
        if (tick && night) begin
          state_next = S_NIGHT;
        end else if (tick && req_reg && (sec_inc >= TG_MIN)) begin
          state_next = S_YELLOW;
        end
`else
        if (tick && req_reg && (sec_inc >= TG_MIN)) begin
          state_next = S_YELLOW;
        end
`endif
      end
      S_YELLOW: if (tick && (sec_inc == TY)) state_next = S_ALLRED;
      S_ALLRED: if (tick && (sec_inc == TA)) state_next = S_WALK;
      S_WALK:   if (tick && (sec_inc == TW)) state_next = S_FLASH;
      S_FLASH:  if (tick && (sec_inc == TF)) state_next = S_GREEN;
`ifdef NIGHT_FLASH_EN
      S_NIGHT:  if (tick && !night) state_next = S_GREEN;
`endif
      default:  state_next = S_GREEN;
    endcase
  end

  // Counter and request updates; a state change restarts both counters,
  // and clearing the request on WALK/NIGHT entry overrides a same-cycle press
  always_comb begin
    entering = (state_next != state_reg);
    serving  = (state_reg == S_GREEN) || (state_reg == S_YELLOW) ||
               (state_reg == S_ALLRED);

    if (entering || tick) begin
      presc_next = '0;
    end else begin
      presc_next = presc_reg + CNT_W'(1);
    end

    if (entering) begin
      sec_next = '0;
    end else if (tick) begin
      sec_next = sec_inc;
    end else begin
      sec_next = sec_reg;
    end

    req_next = req_reg;
    if (N && serving) req_next = 1'b1;
    if (entering && (state_next == S_WALK)) req_next = 1'b0;
`ifdef NIGHT_FLASH_EN
    if (entering && (state_next == S_NIGHT)) req_next = 1'b0;
`endif
  end

  // Moore output decode straight from the registers
  always_comb begin
    car_g    = 1'b0;
    car_y    = 1'b0;
    car_r    = 1'b0;
    ped_walk = 1'b0;
    ped_stop = 1'b0;
    req_pend = req_reg;
    state    = state_reg;
    case (state_reg)
      S_YELLOW: begin
        car_y    = 1'b1;
        ped_stop = 1'b1;
      end
      S_ALLRED: begin
        car_r    = 1'b1;
        ped_stop = 1'b1;
      end
      S_WALK: begin
        car_r    = 1'b1;
        ped_walk = 1'b1;
      end
      S_FLASH: begin
        car_r    = 1'b1;
        ped_walk = (presc_reg < PS_HALF);
      end
`ifdef NIGHT_FLASH_EN
      S_NIGHT: begin
        car_y = (presc_reg < PS_HALF);
      end
`endif
      default: begin
        // GREEN, and any illegal code for the single cycle before recovery
        car_g    = 1'b1;
        ped_stop = 1'b1;
      end
    endcase
  end

endmodule
